ysyx_23060208_dsram_axi: RTL

AXI4-lite responder modelling the data SRAM that the execute stage's load/store engine drives. It accepts independent write-address, write-data and read-address handshakes, performs byte/half/word accesses on an internal word array, and returns write and read responses with a configurable read latency. It sits on the `dsram_*` bus opposite the execute stage and replaces the DPI memory on the data side.

---
 rtl/ysyx_23060208_dsram_axi.sv | 291 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/ysyx_23060208_dsram_axi.sv
// AXI4-lite data SRAM responder for the execute stage's load/store engine.
// Independent write (AW/W/B) and read (AR/R) state machines share one word
// array. Writes take byte/half/word sizes from a one-hot wstrb; reads return
// the addressed word shifted down by the byte offset after RD_LAT wait cycles.
module ysyx_23060208_dsram_axi #(
  parameter int                DATA_WIDTH = 32,
  parameter int                DEPTH      = 4096,
  parameter logic [31:0]       BASE       = 32'h8000_0000,
  parameter int                RD_LAT     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] dsram_awaddr,
  input  logic                  dsram_awvalid,
  output logic                  dsram_awready,
  input  logic [DATA_WIDTH-1:0] dsram_wdata,
  input  logic [2:0]            dsram_wstrb,
  input  logic                  dsram_wvalid,
  output logic                  dsram_wready,
  output logic [1:0]            dsram_bresp,
  output logic                  dsram_bvalid,
  input  logic                  dsram_bready,
  input  logic [DATA_WIDTH-1:0] dsram_araddr,
  input  logic                  dsram_arvalid,
  output logic                  dsram_arready,
  output logic [DATA_WIDTH-1:0] dsram_rdata,
  output logic [1:0]            dsram_rresp,
  output logic                  dsram_rvalid,
  input  logic                  dsram_rready
);

  localparam int                    IW   = $clog2(DEPTH);
  localparam int                    CW   = (RD_LAT < 2) ? 1 : $clog2(RD_LAT);
  localparam logic [DATA_WIDTH-1:0] SPAN = DATA_WIDTH'(4 * DEPTH);

  typedef enum logic [1:0] {
    W_IDLE   = 2'd0,
    W_HAVE_A = 2'd1,
    W_HAVE_D = 2'd2,
    W_RESP   = 2'd3
  } wstate_e;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_RESP = 2'd2
  } rstate_e;

  // True when the byte address falls inside [BASE, BASE + 4*DEPTH).
  function automatic logic in_range_f(input logic [DATA_WIDTH-1:0] addr);
    logic [DATA_WIDTH-1:0] rel;
    rel = addr - BASE;
    return (addr >= BASE) && (rel < SPAN);
  endfunction

  // Word index of a byte address relative to BASE.
  function automatic logic [IW-1:0] idx_f(input logic [DATA_WIDTH-1:0] addr);
    logic [DATA_WIDTH-1:0] rel;
    rel = addr - BASE;
    return rel[IW+1:2];
  endfunction

  // Write response: decode error dominates size/alignment error.
  function automatic logic [1:0] wresp_f(input logic [DATA_WIDTH-1:0] addr,
                                         input logic [2:0] strb);
    logic ok;
    case (strb)
      3'b100:  ok = (addr[1:0] == 2'b00);
      3'b010:  ok = (addr[0] == 1'b0);
      3'b001:  ok = 1'b1;
      default: ok = 1'b0;
    endcase
    if (!in_range_f(addr)) return 2'b11;
    else if (!ok)          return 2'b10;
    else                   return 2'b00;
  endfunction

  // Byte-lane enables for a legal access of the given size at the given offset.
  function automatic logic [3:0] be_f(input logic [2:0] strb, input logic [1:0] off);
    case (strb)
      3'b100:  return 4'b1111;
      3'b010:  return 4'b0011 << off;
      3'b001:  return 4'b0001 << off;
      default: return 4'b0000;
    endcase
  endfunction

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // ---------------- write side ----------------
  wstate_e               wstate_q, wstate_d;
  logic [DATA_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [2:0]            wstrb_q, wstrb_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  aw_hs_s, w_hs_s, w_commit_s;
  logic [DATA_WIDTH-1:0] w_addr_s, w_data_s, w_shift_s;
  logic [2:0]            w_strb_s;
  logic [1:0]            w_resp_s;
  logic [3:0]            w_be_s;
  logic [IW-1:0]         w_idx_s;

  assign dsram_awready = (wstate_q == W_IDLE) || (wstate_q == W_HAVE_D);
  assign dsram_wready  = (wstate_q == W_IDLE) || (wstate_q == W_HAVE_A);
  assign aw_hs_s       = dsram_awvalid && dsram_awready;
  assign w_hs_s        = dsram_wvalid && dsram_wready;

  // The committing beat may arrive this cycle or may already be latched.
  assign w_addr_s   = aw_hs_s ? dsram_awaddr : awaddr_q;
  assign w_data_s   = w_hs_s  ? dsram_wdata  : wdata_q;
  assign w_strb_s   = w_hs_s  ? dsram_wstrb  : wstrb_q;
  assign w_resp_s   = wresp_f(w_addr_s, w_strb_s);
  assign w_be_s     = be_f(w_strb_s, w_addr_s[1:0]);
  assign w_shift_s  = w_data_s << {w_addr_s[1:0], 3'b000};
  assign w_idx_s    = idx_f(w_addr_s);
  assign w_commit_s = (wstate_q != W_RESP) && (wstate_d == W_RESP);

  // Write FSM next state, beat latching and B-channel response generation.
  always_comb begin
    wstate_d = wstate_q;
    awaddr_d = awaddr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    bvalid_d = bvalid_q;
    bresp_d  = bresp_q;
    case (wstate_q)
      W_IDLE: begin
        if (aw_hs_s && w_hs_s) wstate_d = W_RESP;
        else if (aw_hs_s)      wstate_d = W_HAVE_A;
        else if (w_hs_s)       wstate_d = W_HAVE_D;
        else                   wstate_d = W_IDLE;
      end
      W_HAVE_A: begin
        if (w_hs_s) wstate_d = W_RESP;
        else        wstate_d = W_HAVE_A;
      end
      W_HAVE_D: begin
        if (aw_hs_s) wstate_d = W_RESP;
        else         wstate_d = W_HAVE_D;
      end
      W_RESP: begin
        if (dsram_bready) begin
          wstate_d = W_IDLE;
          bvalid_d = 1'b0;
        end else begin
          wstate_d = W_RESP;
        end
      end
      default: wstate_d = W_IDLE;
    endcase
    if (aw_hs_s) awaddr_d = dsram_awaddr;
    else         awaddr_d = awaddr_q;
    if (w_hs_s) begin
      wdata_d = dsram_wdata;
      wstrb_d = dsram_wstrb;
    end else begin
      wdata_d = wdata_q;
      wstrb_d = wstrb_q;
    end
    if (w_commit_s) begin
      bvalid_d = 1'b1;
      bresp_d  = w_resp_s;
    end else begin
      bresp_d  = bresp_q;
    end
  end

  // Write FSM state and latched beats.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wstate_q <= W_IDLE;
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= 3'b000;
      bvalid_q <= 1'b0;
      bresp_q  <= 2'b00;
    end else begin
      wstate_q <= wstate_d;
      awaddr_q <= awaddr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      bvalid_q <= bvalid_d;
      bresp_q  <= bresp_d;
    end
  end

  // Array update on entry to the response state; only enabled lanes change.
  always_ff @(posedge clk) begin
    if (w_commit_s && (w_resp_s == 2'b00)) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be_s[i]) mem_q[w_idx_s][8*i +: 8] <= w_shift_s[8*i +: 8];
      end
    end
  end

  assign dsram_bvalid = bvalid_q;
  assign dsram_bresp  = bresp_q;

  // ---------------- read side ----------------
  rstate_e               rstate_q, rstate_d;
  logic [DATA_WIDTH-1:0] araddr_q, araddr_d;
  logic [CW-1:0]         rcnt_q, rcnt_d;
  logic                  rvalid_q, rvalid_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  ar_hs_s, r_load_s, r_ok_s;
  logic [DATA_WIDTH-1:0] r_addr_s, r_word_s;

  assign dsram_arready = (rstate_q == R_IDLE);
  assign ar_hs_s       = dsram_arvalid && dsram_arready;
  assign r_addr_s      = ar_hs_s ? dsram_araddr : araddr_q;
  assign r_ok_s        = in_range_f(r_addr_s);
  assign r_word_s      = mem_q[idx_f(r_addr_s)];

  // Read FSM next state, latency counter and R-channel response generation.
  always_comb begin
    rstate_d = rstate_q;
    araddr_d = araddr_q;
    rcnt_d   = rcnt_q;
    rvalid_d = rvalid_q;
    rresp_d  = rresp_q;
    rdata_d  = rdata_q;
    r_load_s = 1'b0;
    case (rstate_q)
      R_IDLE: begin
        if (ar_hs_s) begin
          araddr_d = dsram_araddr;
          if (RD_LAT == 0) begin
            rstate_d = R_RESP;
            r_load_s = 1'b1;
          end else begin
            rstate_d = R_WAIT;
            rcnt_d   = CW'(RD_LAT - 1);
          end
        end else begin
          rstate_d = R_IDLE;
        end
      end
      R_WAIT: begin
        if (rcnt_q == '0) begin
          rstate_d = R_RESP;
          r_load_s = 1'b1;
        end else begin
          rcnt_d = rcnt_q - CW'(1);
        end
      end
      R_RESP: begin
        if (dsram_rready) begin
          rstate_d = R_IDLE;
          rvalid_d = 1'b0;
        end else begin
          rstate_d = R_RESP;
        end
      end
      default: rstate_d = R_IDLE;
    endcase
    if (r_load_s) begin
      rvalid_d = 1'b1;
      rresp_d  = r_ok_s ? 2'b00 : 2'b11;
      rdata_d  = r_ok_s ? (r_word_s >> {r_addr_s[1:0], 3'b000}) : '0;
    end else begin
      rresp_d  = rresp_q;
      rdata_d  = rdata_q;
    end
  end

  // Read FSM state, latched address, counter and held response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rstate_q <= R_IDLE;
      araddr_q <= '0;
      rcnt_q   <= '0;
      rvalid_q <= 1'b0;
      rresp_q  <= 2'b00;
      rdata_q  <= '0;
    end else begin
      rstate_q <= rstate_d;
      araddr_q <= araddr_d;
      rcnt_q   <= rcnt_d;
      rvalid_q <= rvalid_d;
      rresp_q  <= rresp_d;
      rdata_q  <= rdata_d;
    end
  end

  assign dsram_rvalid = rvalid_q;
  assign dsram_rresp  = rresp_q;
  assign dsram_rdata  = rdata_q;

endmodule
